// File: rtl/vr_arb_pkg.sv
// Shared types and helpers for the valid/ready round-robin FIFO-write arbiter.
package vr_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // Index width that stays at least one bit, even for a single requester.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular priority encoder: first set request strictly after last_ptr_i, wrapping.
module rr_pick
    import vr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    logic [N-1:0] rot;
    int           first;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        rot   = '0;
        first = 0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req_i[(int'(last_ptr_i) + 1 + i) % N];
        end
        found_o = |rot;
        // Descending scan leaves the lowest rotated position, i.e. the next in turn.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) first = i;
        end
        idx_o = IW'((int'(last_ptr_i) + 1 + first) % N);
    end

endmodule

// File: rtl/vr_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ burst requesters,
// keeping bursts contiguous up to MAX_BURST beats per grant.
module vr_rr_arbiter
    import vr_arb_pkg::*;
#(
    parameter int  N_REQ     = 4,
    parameter int  WIDTH     = 8,
    parameter int  MAX_BURST = 4,
    localparam int IW        = id_width(N_REQ),
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ-1:0]       req_last_i,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic                   fifo_full_i,
    output logic                   fifo_push_o,
    output logic [WIDTH-1:0]       fifo_data_o,
    output logic [IW-1:0]          grant_id_o,
    output logic                   busy_o
);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] last_ptr_q, last_ptr_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] owner;
    logic          has_owner;
    logic          xfer;
    logic          owner_last;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req_i      (req_valid_i),
        .last_ptr_i (last_ptr_q),
        .found_o    (pick_found),
        .idx_o      (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        last_ptr_d = last_ptr_q;
        beat_cnt_d = beat_cnt_q;

        owner     = (state_q == ARB_LOCKED) ? last_ptr_q : pick_idx;
        has_owner = (state_q == ARB_LOCKED) || pick_found;

        // Outputs are gated by rstn_i so they read zero for the whole reset window.
        req_ready_o = '0;
        if (rstn_i && has_owner && !fifo_full_i) req_ready_o[owner] = 1'b1;

        xfer        = |(req_ready_o & req_valid_i);
        owner_last  = req_last_i[owner];
        fifo_push_o = xfer;
        fifo_data_o = xfer ? req_data_i[int'(owner)*WIDTH +: WIDTH] : '0;
        grant_id_o  = (rstn_i && has_owner) ? owner : '0;
        busy_o      = rstn_i && (state_q == ARB_LOCKED);

        if (xfer) begin
            unique case (state_q)
                ARB_IDLE: begin
                    last_ptr_d = owner;
                    if (!owner_last && MAX_BURST > 1) begin
                        state_d    = ARB_LOCKED;
                        beat_cnt_d = CW'(1);
                    end
                end
                ARB_LOCKED: begin
                    // Cap reached: rotate; the remaining beats re-arbitrate as a new burst.
                    if (owner_last || (beat_cnt_q + CW'(1)) == CW'(MAX_BURST)) begin
                        state_d    = ARB_IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ARB_IDLE;
            last_ptr_q <= IW'(N_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q    <= state_d;
            last_ptr_q <= last_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    a_ready_onehot : assert property (@(posedge clk_i) $onehot0(req_ready_o));

    a_cnt_range : assert property (@(posedge clk_i) disable iff (!rstn_i)
        (state_q == ARB_LOCKED) |-> (beat_cnt_q < CW'(MAX_BURST)));

    for (genvar k = 0; k < N_REQ; k++) begin : g_vld
        a_valid_hold : assert property (@(posedge clk_i) disable iff (!rstn_i)
            (req_valid_i[k] && !req_ready_o[k]) |=> req_valid_i[k]);
    end

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// Randomized scoreboard bench for vr_rr_arbiter with a burst-level reference model.
module tb_vr_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    typedef struct {
        logic [W-1:0] data;
        bit           last;
    } beat_t;

    typedef struct {
        int           cyc;
        int           id;
        logic [W-1:0] data;
    } push_t;

    logic           clk_i = 1'b0;
    logic           rstn_i = 1'b0;
    logic [N-1:0]   req_valid_i = '0;
    logic [N-1:0]   req_last_i = '0;
    logic [N*W-1:0] req_data_i = '0;
    logic [N-1:0]   req_ready_o;
    logic           fifo_full_i = 1'b0;
    logic           fifo_push_o;
    logic [W-1:0]   fifo_data_o;
    logic [1:0]     grant_id_o;
    logic           busy_o;

    vr_rr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .fifo_full_i (fifo_full_i),
        .fifo_push_o (fifo_push_o),
        .fifo_data_o (fifo_data_o),
        .grant_id_o  (grant_id_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cur_cyc  = 0;
    int     vprob    = 100;
    bit     in_reset = 1'b1;

    beat_t  src_q [N][$];
    push_t  push_q[$];
    bit [N-1:0] val = '0;

    // Reference model: current burst holder (-1 = none), beats in this grant, last winner.
    int     m_holder = -1;
    int     m_beats  = 0;
    int     m_last   = N - 1;

    logic [N-1:0] exp_ready = '0;
    logic [1:0]   exp_grant = '0;
    logic         exp_busy  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cur_cyc);
        end
    endtask

    task automatic load(input int k, input int nbeats, input bit end_last);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data = W'($urandom);
            b.last = (i == nbeats - 1) && end_last;
            src_q[k].push_back(b);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < N; k++) s += src_q[k].size();
        return s;
    endfunction

    // One cycle: drive inputs, predict the response, then advance to posedge+1.
    task automatic step(input bit full);
        int cand, owner, w, n;
        beat_t b;
        logic [N-1:0]   lv;
        logic [N*W-1:0] dv;
        lv = '0;
        dv = '0;
        for (int k = 0; k < N; k++) begin
            if (!val[k] && src_q[k].size() > 0 && $urandom_range(99) < vprob) val[k] = 1'b1;
            if (val[k]) begin
                lv[k]          = src_q[k][0].last;
                dv[k*W +: W]   = src_q[k][0].data;
            end
        end
        req_valid_i = val;
        req_last_i  = lv;
        req_data_i  = dv;
        fifo_full_i = full;

        cand = -1;
        for (int i = 1; i <= N; i++) begin
            if (cand < 0 && val[(m_last + i) % N]) cand = (m_last + i) % N;
        end
        owner     = (m_holder >= 0) ? m_holder : cand;
        exp_busy  = (m_holder >= 0);
        exp_grant = (owner < 0) ? 2'd0 : 2'(owner);
        exp_ready = (owner >= 0 && !full) ? N'(1 << owner) : '0;

        w = (!full && owner >= 0 && val[owner]) ? owner : -1;
        if (w >= 0) begin
            b = src_q[w].pop_front();
            push_q.push_back('{cyc: cur_cyc, id: w, data: b.data});
            val[w] = 1'b0;
            n      = (m_holder >= 0) ? m_beats + 1 : 1;
            m_last = w;
            if (b.last || n == MB) begin
                m_holder = -1;
                m_beats  = 0;
            end else begin
                m_holder = w;
                m_beats  = n;
            end
        end
        @(posedge clk_i);
        #1;
        cur_cyc++;
    endtask

    task automatic drain();
        int i = 0;
        while (i < 400 && (pending() > 0 || m_holder >= 0)) begin
            step(1'b0);
            i++;
        end
        check("drain_complete", pending(), 0);
    endtask

    task automatic reset_phase(input int ncyc);
        check("sb_empty_pre_reset", push_q.size(), 0);
        rstn_i      = 1'b0;
        in_reset    = 1'b1;
        req_valid_i = '1;
        req_last_i  = '0;
        req_data_i  = {N*W{1'b1}};
        fifo_full_i = 1'b0;
        repeat (ncyc) begin
            @(posedge clk_i);
            #1;
            cur_cyc++;
        end
        req_valid_i = '0;
        req_data_i  = '0;
        val         = '0;
        for (int k = 0; k < N; k++) src_q[k].delete();
        m_holder = -1;
        m_beats  = 0;
        m_last   = N - 1;
        @(posedge clk_i);
        #1;
        cur_cyc++;
        rstn_i   = 1'b1;
        in_reset = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT pushes, and checks status outputs.
    always @(negedge clk_i) begin
        push_t e;
        if (in_reset) begin
            check("rst_ready", req_ready_o, 0);
            check("rst_push", fifo_push_o, 0);
            check("rst_data", fifo_data_o, 0);
            check("rst_grant", grant_id_o, 0);
            check("rst_busy", busy_o, 0);
        end else begin
            check("ready", req_ready_o, exp_ready);
            check("busy", busy_o, exp_busy);
            check("grant", grant_id_o, exp_grant);
            if (fifo_push_o) begin
                if (push_q.size() == 0) begin
                    check("unexpected_push", 1, 0);
                end else begin
                    e = push_q.pop_front();
                    check("push_cycle", cur_cyc, e.cyc);
                    check("push_id", grant_id_o, e.id);
                    check("push_data", fifo_data_o, e.data);
                end
            end else begin
                check("data_when_idle", fifo_data_o, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        rstn_i   = 1'b1;
        in_reset = 1'b0;

        // Single-beat bursts from everyone: strict rotation 0,1,2,3,0.
        for (int k = 0; k < N; k++) load(k, 1, 1'b1);
        load(0, 1, 1'b1);
        drain();

        // Requester 2 locks a 3-beat burst while requester 1 waits.
        load(2, 3, 1'b1);
        step(1'b0);
        load(1, 1, 1'b1);
        drain();

        // Six beats from 0 are split by the cap around requester 3's burst.
        load(0, 6, 1'b1);
        step(1'b0);
        load(3, 2, 1'b1);
        drain();

        // FIFO full for three cycles in mid-burst.
        load(1, 6, 1'b1);
        step(1'b0);
        step(1'b0);
        repeat (3) step(1'b1);
        drain();

        // Owner bubbles for two cycles; requester 0 must not cut in.
        load(1, 1, 1'b0);
        step(1'b0);
        load(0, 1, 1'b1);
        step(1'b0);
        step(1'b0);
        load(1, 2, 1'b1);
        drain();

        // Randomized traffic with random back-pressure.
        vprob = 60;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(7) == 0) begin
                int k = $urandom_range(N - 1);
                if (src_q[k].size() < 8) load(k, $urandom_range(1, 6), 1'b1);
            end
            step($urandom_range(4) == 0);
        end
        drain();

        // Reset in mid-burst, then everyone valid: requester 0 first.
        vprob = 100;
        load(2, 5, 1'b1);
        step(1'b0);
        step(1'b0);
        reset_phase(3);
        for (int k = 0; k < N; k++) load(k, 1, 1'b1);
        drain();

        step(1'b0);
        check("sb_empty_end", push_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
